hex_scroller: RTL



---
 rtl/hex_scroller.sv | 87 ++++++++
 1 files changed

// File: rtl/hex_scroller.sv
// hex_scroller: scrolls MSG right-to-left across HEX5..HEX0, KEY[0] pause, KEY[1] restart.
// Define HEX_SCROLL_GAP_EN to append six blank characters before the message repeats.
module hex_scroller #(
   parameter int TICK_DIV        = 25000000,
   parameter int MSG_LEN         = 16,
   parameter int DEBOUNCE_CYCLES = 500000
) (
   input  logic                   CLOCK_50,
   input  logic                   RESET,
   input  logic [1:0]             KEY,
   input  logic [8*MSG_LEN-1:0]   MSG,
   output logic [7:0]             HEX0,
   output logic [7:0]             HEX1,
   output logic [7:0]             HEX2,
   output logic [7:0]             HEX3,
   output logic [7:0]             HEX4,
   output logic [7:0]             HEX5
);
`ifdef HEX_SCROLL_GAP_EN
   localparam int L = MSG_LEN + 6;
`else
   localparam int L = MSG_LEN;
`endif
   localparam int IW = $clog2(L + 6);
   localparam int PW = $clog2(TICK_DIV);
   localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
   logic [1:0]    s1, s2, lvl, press;
   logic [DW-1:0] cnt [2];
   logic [IW-1:0] pos, idx;
   logic [PW-1:0] pre;
   logic          paused, tick;
   logic [8*L-1:0] seq;
   logic [7:0]    win [6];
`ifdef HEX_SCROLL_GAP_EN
   assign seq = {{6{8'hFF}}, MSG};
`else
   assign seq = MSG;
`endif
   always_ff @(posedge CLOCK_50)
      if (RESET) begin
         s1 <= 2'b11;
         s2 <= 2'b11;
         lvl <= 2'b11;
         press <= 2'b00;
         for (int k = 0; k < 2; k++) cnt[k] <= '0;
      end else begin
         s1 <= KEY;
         s2 <= s1;
         for (int k = 0; k < 2; k++) begin
            press[k] <= 1'b0;
            if (s2[k] == lvl[k]) cnt[k] <= '0;
            else if (cnt[k] == DW'(DEBOUNCE_CYCLES - 1)) begin
               cnt[k] <= '0;
               lvl[k] <= s2[k];
               press[k] <= ~s2[k];
            end else cnt[k] <= cnt[k] + DW'(1);
         end
      end
   assign tick = !paused && pre == PW'(TICK_DIV - 1);
   // restart overrides a coincident tick; pause toggles independently of both
   always_ff @(posedge CLOCK_50)
      if (RESET) begin
         pos <= '0;
         pre <= '0;
         paused <= 1'b0;
      end else begin
         paused <= paused ^ press[0];
         if (press[1]) begin
            pos <= '0;
            pre <= '0;
         end else if (tick) begin
            pre <= '0;
            pos <= (pos == IW'(L - 1)) ? '0 : pos + IW'(1);
         end else if (!paused) pre <= pre + PW'(1);
      end
   always_comb begin
      idx = '0;
      for (int j = 0; j < 6; j++) begin
         idx = pos + IW'(j);
         idx = (idx >= IW'(L)) ? idx - IW'(L) : idx;
         win[j] = seq[8*int'(idx) +: 8];
      end
   end
   always_ff @(posedge CLOCK_50)
      if (RESET) {HEX5, HEX4, HEX3, HEX2, HEX1, HEX0} <= '1;
      else {HEX5, HEX4, HEX3, HEX2, HEX1, HEX0} <= {win[0], win[1], win[2], win[3], win[4], win[5]};
endmodule
